// File: rtl/bank_pkg.sv
// bank_pkg
//   Shared constants for the bank-response gather path: lane count, bank
//   count, lane-tag width, the "no lane" tag value and the gather FSM state
//   encoding.
package bank_pkg;

  localparam int VEC     = 16;  // hash-lookup lanes
  localparam int NBANK   = 32;  // hash-table banks
  localparam int LANE_W  = 5;   // width of a lane tag
  localparam int BSEL_W  = 5;   // width of a bank index
  localparam int NO_LANE = 16;  // tag value meaning "no lane"

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GATHER = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

endpackage : bank_pkg

// File: rtl/lane_bank_match.sv
// lane_bank_match
//   Purely combinational matcher for one lane: finds the banks whose valid
//   response carries this lane's tag.
//   Ports:
//     lane_idx_i : tag value owned by this lane
//     valid_i    : per-bank response strobes
//     tag_i      : flattened per-bank lane tags, bank b at [b*LANE_W +: LANE_W]
//     hit_o      : at least one bank answered this lane
//     sel_o      : lowest-index bank that answered (0 when no hit)
//     multi_o    : more than one bank answered this lane
module lane_bank_match
  import bank_pkg::*;
(
  input  logic [LANE_W-1:0]       lane_idx_i,
  input  logic [NBANK-1:0]        valid_i,
  input  logic [NBANK*LANE_W-1:0] tag_i,
  output logic                    hit_o,
  output logic [BSEL_W-1:0]       sel_o,
  output logic                    multi_o
);

  logic [NBANK-1:0] match;
  logic             seen;

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_match
      assign match[gi] = valid_i[gi] && (tag_i[gi*LANE_W +: LANE_W] == lane_idx_i);
    end
  endgenerate

  // Ascending scan: the first match found keeps the select, any later
  // match only flags the collision.
  always_comb begin
    hit_o   = |match;
    sel_o   = '0;
    multi_o = 1'b0;
    seen    = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      if (match[b]) begin
        if (seen) begin
          multi_o = 1'b1;
        end else begin
          sel_o = BSEL_W'(b);
        end
        seen = 1'b1;
      end
    end
  end

endmodule : lane_bank_match

// File: rtl/gather_bank_response.sv
// gather_bank_response
//   Collects tagged bank read responses for one hash lookup and presents
//   them to the 16 lanes as a single aligned vector.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     req_valid/mask  : start a lookup; mask bit i = lane i expects data
//     req_ready       : high in IDLE (decoded from state)
//     bank_rsp_valid  : per-bank response strobes
//     bank_rsp_lane   : flattened lane tags, bank b at [b*5 +: 5]
//     bank_rsp_data   : flattened data, bank b at [b*DATA_W +: DATA_W]
//     out_valid/ready : gathered-vector handshake
//     out_data        : lane i at [i*DATA_W +: DATA_W], unrequested lanes 0
//     out_mask        : copy of the accepted request mask
//     err             : sticky protocol error, cleared only by reset
module gather_bank_response
  import bank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [VEC-1:0]          req_mask,
  output logic                    req_ready,
  input  logic [NBANK-1:0]        bank_rsp_valid,
  input  logic [NBANK*LANE_W-1:0] bank_rsp_lane,
  input  logic [NBANK*DATA_W-1:0] bank_rsp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VEC*DATA_W-1:0]   out_data,
  output logic [VEC-1:0]          out_mask,
  output logic                    err
);

  logic [1:0]            state_q, state_d;
  logic [VEC-1:0]        pending_q, pending_d;
  logic                  out_valid_q, out_valid_d;
  logic [VEC-1:0]        out_mask_q, out_mask_d;
  logic [VEC*DATA_W-1:0] out_data_q, out_data_d;
  logic                  err_q, err_d;

  logic [VEC-1:0]        lane_hit;
  logic [VEC-1:0]        lane_multi;
  logic [BSEL_W-1:0]     lane_sel [VEC];
  logic [DATA_W-1:0]     lane_rsp_data [VEC];
  logic [NBANK-1:0]      bank_stray;

  generate
    for (genvar gi = 0; gi < VEC; gi++) begin : g_lane
      lane_bank_match u_match (
        .lane_idx_i (LANE_W'(gi)),
        .valid_i    (bank_rsp_valid),
        .tag_i      (bank_rsp_lane),
        .hit_o      (lane_hit[gi]),
        .sel_o      (lane_sel[gi]),
        .multi_o    (lane_multi[gi])
      );
      assign lane_rsp_data[gi] = bank_rsp_data[lane_sel[gi]*DATA_W +: DATA_W];
    end

    // A valid response tagged NO_LANE (or anything beyond the lane range)
    // belongs to nobody.
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_stray
      assign bank_stray[gi] = bank_rsp_valid[gi] &&
                              (bank_rsp_lane[gi*LANE_W +: LANE_W] >= LANE_W'(VEC));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        // No lookup is open, so any response is unexpected.
        if (|bank_rsp_valid) err_d = 1'b1;
        if (req_valid) begin
          pending_d  = req_mask;
          out_mask_d = req_mask;
          out_data_d = '0;
          if (req_mask == '0) begin
            state_d     = ST_OUTPUT;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_GATHER;
          end
        end
      end

      ST_GATHER: begin
        if (|bank_stray) err_d = 1'b1;
        for (int i = 0; i < VEC; i++) begin
          if (lane_hit[i]) begin
            if (lane_multi[i]) err_d = 1'b1;
            if (pending_q[i]) begin
              out_data_d[i*DATA_W +: DATA_W] = lane_rsp_data[i];
              pending_d[i]                   = 1'b0;
            end else begin
              // Duplicate or unrequested: keep the data already captured.
              err_d = 1'b1;
            end
          end
        end
        if (pending_d == '0) begin
          state_d     = ST_OUTPUT;
          out_valid_d = 1'b1;
        end
      end

      ST_OUTPUT: begin
        if (|bank_rsp_valid) err_d = 1'b1;
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        pending_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule : gather_bank_response

// File: tb/tb_gather_bank_response.sv
// tb_gather_bank_response
//   Directed bench for gather_bank_response with a scoreboard of expected
//   output vectors.
module tb_gather_bank_response;
  import bank_pkg::*;

  localparam int DATA_W = 32;
  localparam int OUT_W  = VEC*DATA_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    req_valid;
  logic [VEC-1:0]          req_mask;
  logic                    req_ready;
  logic [NBANK-1:0]        bank_rsp_valid;
  logic [NBANK*LANE_W-1:0] bank_rsp_lane;
  logic [NBANK*DATA_W-1:0] bank_rsp_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic [VEC-1:0]          out_mask;
  logic                    err;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [VEC-1:0]   mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  gather_bank_response #(.DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_mask       (req_mask),
    .req_ready      (req_ready),
    .bank_rsp_valid (bank_rsp_valid),
    .bank_rsp_lane  (bank_rsp_lane),
    .bank_rsp_data  (bank_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_mask       (out_mask),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_rsp();
    bank_rsp_valid = '0;
    bank_rsp_lane  = '0;
    bank_rsp_data  = '0;
  endtask

  task automatic set_rsp(input int b, input logic [LANE_W-1:0] tag, input logic [DATA_W-1:0] d);
    bank_rsp_valid[b]                 = 1'b1;
    bank_rsp_lane[b*LANE_W +: LANE_W] = tag;
    bank_rsp_data[b*DATA_W +: DATA_W] = d;
  endtask

  // Bounded wait for req_ready, then one-cycle request pulse; the expected
  // vector is queued at the moment the stimulus is driven.
  task automatic do_req(input string tag, input logic [VEC-1:0] m, input logic [OUT_W-1:0] exp_data);
    exp_t e;
    int   n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready_wait"}, OUT_W'(req_ready), OUT_W'(1));
    e.data = exp_data;
    e.mask = m;
    sb.push_back(e);
    req_valid = 1'b1;
    req_mask  = m;
    step();
    req_valid = 1'b0;
    req_mask  = '0;
    chk({tag, "_accepted"}, OUT_W'(req_ready), OUT_W'(0));
  endtask

  // Compare the presented vector against the head of the scoreboard.
  task automatic cmp_out(input string tag, input bit do_pop);
    exp_t e;
    chk({tag, "_out_valid"}, OUT_W'(out_valid), OUT_W'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty observed=output expected=none", tag);
    end else begin
      e = sb[0];
      if (do_pop) void'(sb.pop_front());
      chk({tag, "_data"}, out_data, e.data);
      chk({tag, "_mask"}, OUT_W'(out_mask), OUT_W'(e.mask));
    end
    $display("txn %s: out_mask=%h err=%b", tag, out_mask, err);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, OUT_W'(out_valid), OUT_W'(0));
    chk({tag, "_idle"}, OUT_W'(req_ready), OUT_W'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    sb.delete();
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [OUT_W-1:0] exp_v;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mask  = '0;
    out_ready = 1'b0;
    clr_rsp();
    step();
    chk("rst_req_ready", OUT_W'(req_ready), OUT_W'(1));
    chk("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask", OUT_W'(out_mask), '0);
    chk("rst_err", OUT_W'(err), '0);
    #3 rst_n = 1'b1;
    step();

    // Single-cycle gather of all 16 lanes.
    exp_v = '0;
    for (int i = 0; i < VEC; i++) exp_v[i*DATA_W +: DATA_W] = DATA_W'(32'h100 + i);
    do_req("full", 16'hFFFF, exp_v);
    for (int b = 0; b < VEC; b++) set_rsp(b, LANE_W'(b), DATA_W'(32'h100 + b));
    step();
    clr_rsp();
    cmp_out("full", 1'b1);
    chk("full_err", OUT_W'(err), '0);
    handshake("full");

    // Serialised conflicts: bank 5 answers lanes 0,1,2 on consecutive cycles.
    exp_v = '0;
    for (int i = 0; i < 3; i++) exp_v[i*DATA_W +: DATA_W] = DATA_W'(32'h50 + i);
    do_req("serial", 16'h0007, exp_v);
    for (int i = 0; i < 3; i++) begin
      clr_rsp();
      set_rsp(5, LANE_W'(i), DATA_W'(32'h50 + i));
      chk("serial_not_done", OUT_W'(out_valid), OUT_W'(0));
      step();
    end
    clr_rsp();
    cmp_out("serial", 1'b1);
    chk("serial_err", OUT_W'(err), '0);
    handshake("serial");

    // Zero mask with four cycles of backpressure.
    do_req("zero", 16'h0000, '0);
    for (int k = 0; k < 4; k++) begin
      cmp_out("zero_hold", 1'b0);
      step();
    end
    cmp_out("zero", 1'b1);
    handshake("zero");

    // Two banks tag lane 0: lowest bank wins, err is raised.
    exp_v = '0;
    exp_v[DATA_W-1:0] = 32'hA;
    do_req("multi", 16'h0001, exp_v);
    set_rsp(3, 5'd0, 32'hA);
    set_rsp(7, 5'd0, 32'hB);
    step();
    clr_rsp();
    cmp_out("multi", 1'b1);
    chk("multi_err", OUT_W'(err), OUT_W'(1));
    handshake("multi");

    // Stray NO_LANE response while idle.
    do_reset();
    chk("stray_err_clear", OUT_W'(err), '0);
    set_rsp(2, LANE_W'(NO_LANE), 32'hDEAD);
    step();
    clr_rsp();
    chk("stray_err", OUT_W'(err), OUT_W'(1));
    chk("stray_idle", OUT_W'(req_ready), OUT_W'(1));
    chk("stray_out_valid", OUT_W'(out_valid), OUT_W'(0));
    $display("txn stray: err=%b req_ready=%b", err, req_ready);

    // Reset in the middle of a gather.
    do_reset();
    do_req("abort", 16'h00FF, '0);
    for (int b = 0; b < 4; b++) set_rsp(b, LANE_W'(b), DATA_W'(32'h200 + b));
    step();
    clr_rsp();
    chk("abort_partial", OUT_W'(out_valid), OUT_W'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", OUT_W'(req_ready), OUT_W'(1));
    chk("abort_out_data", out_data, '0);
    chk("abort_out_mask", OUT_W'(out_mask), '0);
    chk("abort_err", OUT_W'(err), '0);
    sb.delete();
    $display("txn abort: reset asserted mid-gather");
    step();
    #3 rst_n = 1'b1;
    exp_v = '0;
    exp_v[DATA_W-1:0] = 32'h99;
    do_req("after", 16'h0001, exp_v);
    set_rsp(9, 5'd0, 32'h99);
    step();
    clr_rsp();
    cmp_out("after", 1'b1);
    handshake("after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gather_bank_response
